// File: rtl/doa_peak_search.sv
// Angle-scan controller for the ULA DOA chain: drives one (angle, snapshot) request at a time
// into the power stage, sums the returned powers per angle and tracks the strict arg-max.
module doa_peak_search #(
  parameter int PWR_W    = 71,
  parameter int N_ANGLES = 181,
  parameter int ANGLE_W  = 8,
  parameter int N_SNAP   = 64,
  parameter int SNAP_W   = 6,
  parameter int ACC_W    = PWR_W + SNAP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [ANGLE_W-1:0] req_angle,
  output logic [SNAP_W-1:0]  req_snap,
  input  logic               pwr_valid,
  input  logic [PWR_W-1:0]   pwr_in,
  output logic               busy,
  output logic               done,
  output logic [ANGLE_W-1:0] best_angle,
  output logic [ACC_W-1:0]   best_power
);

  localparam logic [ANGLE_W-1:0] LAST_ANGLE = ANGLE_W'(N_ANGLES - 1);
  localparam logic [SNAP_W-1:0]  LAST_SNAP  = SNAP_W'(N_SNAP - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   run_best;
  logic [ANGLE_W-1:0] angle;
  logic [ANGLE_W-1:0] run_angle;
  logic [SNAP_W-1:0]  snap;

  logic               new_best;
  logic [ANGLE_W-1:0] cand_angle;
  logic [ACC_W-1:0]   cand_power;

  assign req_angle = angle;
  assign req_snap  = snap;

  // Strict compare keeps the lowest angle on ties; cand_* is the running best including this angle,
  // so the final result can be published in the same edge that leaves CMP.
  always_comb begin
    new_best = (acc > run_best);
    if (new_best) begin
      cand_angle = angle;
      cand_power = acc;
    end else begin
      cand_angle = run_angle;
      cand_power = run_best;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= {ACC_W{1'b0}};
      run_best   <= {ACC_W{1'b0}};
      angle      <= {ANGLE_W{1'b0}};
      run_angle  <= {ANGLE_W{1'b0}};
      snap       <= {SNAP_W{1'b0}};
      req_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      best_angle <= {ANGLE_W{1'b0}};
      best_power <= {ACC_W{1'b0}};
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc       <= {ACC_W{1'b0}};
            run_best  <= {ACC_W{1'b0}};
            angle     <= {ANGLE_W{1'b0}};
            run_angle <= {ANGLE_W{1'b0}};
            snap      <= {SNAP_W{1'b0}};
            busy      <= 1'b1;
            req_valid <= 1'b1;
            state     <= S_REQ;
          end else begin
            state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= S_WAIT;
          end else begin
            state <= S_REQ;
          end
        end
        S_WAIT: begin
          if (pwr_valid) begin
            acc <= acc + ACC_W'(pwr_in);
            if (snap == LAST_SNAP) begin
              state <= S_CMP;
            end else begin
              snap      <= snap + SNAP_W'(1);
              req_valid <= 1'b1;
              state     <= S_REQ;
            end
          end else begin
            state <= S_WAIT;
          end
        end
        S_CMP: begin
          run_best  <= cand_power;
          run_angle <= cand_angle;
          acc       <= {ACC_W{1'b0}};
          snap      <= {SNAP_W{1'b0}};
          if (angle == LAST_ANGLE) begin
            best_angle <= cand_angle;
            best_power <= cand_power;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= S_DONE;
          end else begin
            angle     <= angle + ANGLE_W'(1);
            req_valid <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          req_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_doa_peak_search.sv
// Randomised bench for doa_peak_search with a table-driven upstream and an arg-max reference model.
module tb_doa_peak_search;

  localparam int PWR_W    = 71;
  localparam int N_ANGLES = 8;
  localparam int ANGLE_W  = 3;
  localparam int N_SNAP   = 4;
  localparam int SNAP_W   = 2;
  localparam int ACC_W    = PWR_W + SNAP_W;
  localparam int SCAN_LAT = N_ANGLES * (2 * N_SNAP + 1) + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               req_valid;
  logic               req_ready = 1'b0;
  logic [ANGLE_W-1:0] req_angle;
  logic [SNAP_W-1:0]  req_snap;
  logic               pwr_valid = 1'b0;
  logic [PWR_W-1:0]   pwr_in = '0;
  logic               busy;
  logic               done;
  logic [ANGLE_W-1:0] best_angle;
  logic [ACC_W-1:0]   best_power;

  always #5 clk = ~clk;

  doa_peak_search #(
    .PWR_W(PWR_W), .N_ANGLES(N_ANGLES), .ANGLE_W(ANGLE_W),
    .N_SNAP(N_SNAP), .SNAP_W(SNAP_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .req_valid(req_valid), .req_ready(req_ready), .req_angle(req_angle), .req_snap(req_snap),
    .pwr_valid(pwr_valid), .pwr_in(pwr_in),
    .busy(busy), .done(done), .best_angle(best_angle), .best_power(best_power)
  );

  logic [PWR_W-1:0] pwr_tab [N_ANGLES][N_SNAP];
  bit ideal = 1'b1;
  bit spurious = 1'b0;
  int n_checks = 0;
  int n_pass = 0;
  int n_done = 0;
  int mon_idx = 0;
  bit mon_out = 1'b0;

  task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: sum every snapshot per angle, keep the first angle with the strictly largest sum.
  task automatic model_best(output logic [ANGLE_W-1:0] a_best, output logic [ACC_W-1:0] p_best);
    p_best = '0;
    a_best = '0;
    for (int a = 0; a < N_ANGLES; a++) begin
      logic [ACC_W-1:0] sum;
      sum = '0;
      for (int s = 0; s < N_SNAP; s++) sum = sum + ACC_W'(pwr_tab[a][s]);
      if (sum > p_best) begin
        p_best = sum;
        a_best = ANGLE_W'(a);
      end
    end
  endtask

  // Upstream power stage: answers each accepted request after 1 (ideal) or 1..7 cycles.
  initial begin : upstream
    int cd;
    logic [PWR_W-1:0] pend;
    cd = 0;
    pend = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cd = 0;
        pwr_valid = 1'b0;
        req_ready = 1'b0;
      end else begin
        pwr_valid = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            pwr_valid = 1'b1;
            pwr_in = pend;
          end
        end else if (spurious && !busy && ($urandom_range(0, 99) < 25)) begin
          pwr_valid = 1'b1;
          pwr_in = PWR_W'({$urandom, $urandom, $urandom});
        end
        req_ready = ideal ? 1'b1 : ($urandom_range(0, 99) < 30);
        if (req_valid && req_ready) begin
          pend = pwr_tab[req_angle][req_snap];
          cd = ideal ? 1 : int'($urandom_range(1, 7));
        end
      end
    end
  end

  // Single compare process: request order, stability under stall, busy/done framing and results.
  initial begin : monitor
    bit active, prev_stall;
    int cyc, start_cyc;
    logic [ANGLE_W-1:0] pa, ea;
    logic [SNAP_W-1:0] ps;
    logic [ACC_W-1:0] ep;
    active = 1'b0; prev_stall = 1'b0; cyc = 0; start_cyc = 0;
    pa = '0; ps = '0; ea = '0; ep = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        active = 1'b0; prev_stall = 1'b0; mon_idx = 0; mon_out = 1'b0;
        chk("reset_ctrl", ACC_W'({req_valid, busy, done}), '0);
        chk("reset_result", best_power | ACC_W'(best_angle) | ACC_W'(req_angle) | ACC_W'(req_snap), '0);
      end else begin
        chk("busy", ACC_W'(busy), ACC_W'(active && !done));
        if (done) begin
          chk("done_expected", ACC_W'(active && mon_idx == N_ANGLES * N_SNAP && !mon_out), ACC_W'(1));
          chk("best_angle", ACC_W'(best_angle), ACC_W'(ea));
          chk("best_power", best_power, ep);
          if (ideal) chk("scan_latency", ACC_W'(cyc - start_cyc), ACC_W'(SCAN_LAT));
          active = 1'b0;
          n_done++;
        end
        if (!active) chk("idle_no_req", ACC_W'(req_valid), '0);
        if (prev_stall) begin
          chk("stall_valid", ACC_W'(req_valid), ACC_W'(1));
          chk("stall_angle", ACC_W'(req_angle), ACC_W'(pa));
          chk("stall_snap", ACC_W'(req_snap), ACC_W'(ps));
        end
        prev_stall = req_valid && !req_ready;
        pa = req_angle;
        ps = req_snap;
        if (pwr_valid && mon_out) mon_out = 1'b0;
        if (req_valid && req_ready) begin
          chk("single_outstanding", ACC_W'(mon_out), '0);
          chk("req_angle", ACC_W'(req_angle), ACC_W'(mon_idx / N_SNAP));
          chk("req_snap", ACC_W'(req_snap), ACC_W'(mon_idx % N_SNAP));
          mon_idx++;
          mon_out = 1'b1;
        end
        if (start && !active && !done) begin
          active = 1'b1;
          mon_idx = 0;
          mon_out = 1'b0;
          start_cyc = cyc;
          model_best(ea, ep);
        end
      end
    end
  end

  task automatic wait_done(input int budget);
    int d0;
    d0 = n_done;
    for (int i = 0; i < budget && n_done == d0; i++) begin
      @(negedge clk);
      #2;
    end
    chk("done_timeout", ACC_W'(n_done != d0), ACC_W'(1));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill_random();
    for (int a = 0; a < N_ANGLES; a++)
      for (int s = 0; s < N_SNAP; s++)
        pwr_tab[a][s] = PWR_W'($urandom_range(0, 20));
  endtask

  initial begin : main
    logic [ANGLE_W-1:0] ma;
    logic [ACC_W-1:0] mp;
    int d0;
    bit hit;

    for (int a = 0; a < N_ANGLES; a++)
      for (int s = 0; s < N_SNAP; s++) pwr_tab[a][s] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_outputs", ACC_W'({req_valid, busy, done, best_angle}) | best_power, '0);

    // All-zero scan: result must be angle 0, power 0.
    pulse_start();
    wait_done(2000);
    chk("zero_angle", ACC_W'(best_angle), '0);
    chk("zero_power", best_power, '0);

    // Single peak at angle 5.
    for (int a = 0; a < N_ANGLES; a++)
      for (int s = 0; s < N_SNAP; s++) pwr_tab[a][s] = (a == 5) ? PWR_W'(1000) : PWR_W'(10);
    model_best(ma, mp);
    chk("model_peak_power", mp, ACC_W'(4000));
    pulse_start();
    wait_done(2000);
    chk("peak_angle", ACC_W'(best_angle), ACC_W'(5));
    chk("peak_power", best_power, ACC_W'(4000));

    // Tie between angles 2 and 6 at full-scale power.
    for (int a = 0; a < N_ANGLES; a++)
      for (int s = 0; s < N_SNAP; s++) pwr_tab[a][s] = (a == 2 || a == 6) ? {PWR_W{1'b1}} : '0;
    model_best(ma, mp);
    chk("model_tie_power", mp, 73'h1_FFFF_FFFF_FFFF_FFFF_FC);
    pulse_start();
    wait_done(2000);
    chk("tie_angle", ACC_W'(best_angle), ACC_W'(2));
    chk("tie_power", best_power, 73'h1_FFFF_FFFF_FFFF_FFFF_FC);

    // Random tables, ideal then stalled upstream with spurious pwr_valid while idle.
    for (int r = 0; r < 3; r++) begin
      fill_random();
      ideal = 1'b1;
      pulse_start();
      wait_done(2000);
      ideal = 1'b0;
      spurious = 1'b1;
      repeat (5) @(negedge clk);
      pulse_start();
      wait_done(20000);
      repeat (5) @(negedge clk);
    end

    // Restart attempts mid-scan and in the done cycle are ignored.
    fill_random();
    d0 = n_done;
    pulse_start();
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("single_done", ACC_W'(n_done - d0), ACC_W'(1));
    chk("idle_after_done", ACC_W'(busy), '0);
    fill_random();
    pulse_start();
    wait_done(20000);

    // Reset while waiting on a response at angle 3.
    fill_random();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 20000 && !hit; i++) begin
      @(negedge clk);
      #2;
      hit = mon_out && ((mon_idx - 1) / N_SNAP == 3);
    end
    chk("reached_angle3", ACC_W'(hit), ACC_W'(1));
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    chk("midscan_reset_ctrl", ACC_W'({req_valid, busy, done}), '0);
    chk("midscan_reset_result", best_power | ACC_W'(best_angle), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", ACC_W'(n_done - d0), '0);
    pulse_start();
    wait_done(20000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
